cp0_exc_seq: RTL and testbench
==============================

// Module: cp0_exc_seq
// PURPOSE
//  Exception/ERET sequencer and write-port arbiter for CP0, sitting between the MEM (commit) stage and CP0.
//  CP0 has a single write port. An exception commit needs several CP0 writes (EPC, BadVAddr, Cause, Status),
//  so this block serialises them, stalls the pipeline meanwhile, then flushes and redirects fetch.
//  Also arbitrates pipeline MTC0 writes and decides hardware-interrupt acceptance.
// PARAMETERS
//  EXC_VECTOR  32'hBFC00380  redirect PC for every exception/interrupt
//  ADDR_W      5             CP0 register address width
//  INT_W       6             hardware interrupt lines (Cause.IP[7:2])
// PORTS
//  clk             in   1   clock; all state changes on rising edge
//  rst             in   1   asynchronous, active-low reset (0 = reset)
//  mem_valid_i     in   1   a valid instruction is at commit this cycle
//  mem_pc_i        in   32  PC of the committing instruction
//  mem_bd_i        in   1   committing instruction sits in a branch delay slot
//  exc_valid_i     in   1   committing instruction raised a synchronous exception
//  exc_code_i      in   5   ExcCode (4 AdEL, 5 AdES, 8 Sys, 9 Bp, 10 RI, 12 Ov)
//  exc_badvaddr_i  in   32  faulting address (meaningful for codes 4/5)
//  eret_i          in   1   committing instruction is ERET
//  mtc0_en_i       in   1   committing instruction is MTC0
//  mtc0_addr_i     in   5   MTC0 target register
//  mtc0_data_i     in   32  MTC0 data
//  int_i           in   6   raw hardware interrupt lines, level sensitive
//  status_i        in   32  live CP0 Status
//  cause_i         in   32  live CP0 Cause
//  epc_i           in   32  live CP0 EPC
//  cp0_write_en    out  1   CP0 write strobe (registered)
//  cp0_write_addr  out  5   CP0 write address (registered)
//  cp0_write_data  out  32  CP0 write data (registered)
//  cp0_hw_wr       out  1   hardware write: CP0 updates Cause.BD/ExcCode and Status.EXL unmasked
//  stall_o         out  1   hold the pipeline (combinational)
//  flush_o         out  1   one-cycle flush of all younger stages (registered)
//  redirect_pc_o   out  32  fetch target, valid only while flush_o=1
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; all outputs 0; redirect_pc_o=0; all latches cleared.
//  - int_req = Status.IE(0) & ~Status.EXL(1) & |(int_i & Status.IM[15:10]).
//  - Event priority in IDLE: interrupt (int_req & mem_valid_i, code 0) > exc_valid_i > eret_i > mtc0_en_i.
//    The winner masks the rest; a masked MTC0 of an excepting instruction is dropped, never issued later.
//  - On an exception/interrupt accept at edge T, latch code, pc, bd, badvaddr and EXL_old=Status.EXL.
//    stall_o=1 in the accept cycle and in every non-IDLE state.
//  - FSM: IDLE -> S_EPC -> [S_BADV] -> S_CAUSE -> S_STATUS -> S_FLUSH -> IDLE; one cycle per state.
//  - S_EPC: addr 14, data = bd ? pc-4 : pc. Skipped (IDLE -> S_BADV/S_CAUSE) when EXL_old=1, so EPC is preserved.
//  - S_BADV: addr 8, data = badvaddr. Entered only for code 4/5.
//  - S_CAUSE: addr 13, data = cause_i with [31]=bd and [6:2]=code.
//  - S_STATUS: addr 12, data = status_i with [1]=1.
//  - cp0_hw_wr=1 during S_EPC, S_BADV, S_CAUSE and S_STATUS.
//  - S_FLUSH: flush_o=1, redirect_pc_o=EXC_VECTOR, no write.
//  - Latency, no-BadVAddr exception: writes at T+1..T+3, flush at T+4; with BadVAddr, flush at T+5.
//  - ERET: latch epc_i at accept. IDLE -> S_ERET (addr 12, status_i with [1]=0, hw_wr=1) -> S_FLUSH with
//    redirect_pc_o = latched EPC.
//  - MTC0 in IDLE with no higher event: the registered write appears the next cycle, hw_wr=0, no stall.
//    This holds for back-to-back MTC0s.
//  - No new event is accepted outside IDLE; inputs are ignored while busy (the pipeline is held).
//  - Async reset mid-sequence: abort to IDLE immediately. CP0 writes already issued are not undone.
// STRUCTURE
//  - cp0exc.v (shared): CP0 register addresses (8, 9, 11, 12, 13, 14), ExcCodes, Status.IE/EXL,
//    Cause.BD/ExcCode/IP and Status.IM bit positions, and EXC_VECTOR default.
//  - FSM state encoding stays local to this block.
//  - Sub-module cp0_int_detect: combinational int_req from int_i, status_i and mem_valid_i.
// TESTING
//  1. Reset low mid-S_CAUSE -> next sample: state IDLE, cp0_write_en=0, flush_o=0, stall_o=0.
//  2. Ov (code 12) at pc 0x80001000, bd=1, EXL=0 -> EPC<=0x80000FFC, Cause[6:2]=12, Cause[31]=1,
//     Status[1]=1; flush at T+4 with redirect 0xBFC00380.
//  3. AdEL with badvaddr 0x80000003 -> extra S_BADV write (addr 8, 0x80000003); flush at T+5.
//  4. ERET with EPC=0x80002000 -> Status[1]=0 write at T+1; flush at T+2, redirect 0x80002000.
//  5. int_i=6'b000001, IE=1, IM[10]=1, EXL=0, with simultaneous MTC0 -> interrupt wins (code 0), MTC0 dropped;
//     repeat with EXL=1 -> no interrupt, MTC0 written the next cycle.
//  6. Sys exception while EXL=1 -> no EPC write; Cause then Status writes, flush at T+3; EPC unchanged.

Source files
------------

// File: rtl/cp0_exc_seq_pkg.sv
// Shared CP0 definitions: register addresses, exception codes, bit positions
// and the default exception vector used by the exception sequencer.
package cp0_exc_seq_pkg;

  // CP0 register addresses
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Status / Cause field positions
  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_LO = 10;
  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO  = 10;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

  // Address-error exceptions are the only ones that also record BadVAddr.
  function automatic logic has_badvaddr(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_exc_seq_if.sv
// Commit-stage / CP0 bundle around the exception sequencer.
// slave = the sequencer, master = the pipeline/CP0 side driving it.
interface cp0_exc_seq_if #(
  parameter int ADDR_W = 5,
  parameter int INT_W  = 6
);
  logic              mem_valid_i;
  logic [31:0]       mem_pc_i;
  logic              mem_bd_i;
  logic              exc_valid_i;
  logic [4:0]        exc_code_i;
  logic [31:0]       exc_badvaddr_i;
  logic              eret_i;
  logic              mtc0_en_i;
  logic [ADDR_W-1:0] mtc0_addr_i;
  logic [31:0]       mtc0_data_i;
  logic [INT_W-1:0]  int_i;
  logic [31:0]       status_i;
  logic [31:0]       cause_i;
  logic [31:0]       epc_i;
  logic              cp0_write_en;
  logic [ADDR_W-1:0] cp0_write_addr;
  logic [31:0]       cp0_write_data;
  logic              cp0_hw_wr;
  logic              stall_o;
  logic              flush_o;
  logic [31:0]       redirect_pc_o;

  modport slave (
    input  mem_valid_i, mem_pc_i, mem_bd_i, exc_valid_i, exc_code_i, exc_badvaddr_i,
           eret_i, mtc0_en_i, mtc0_addr_i, mtc0_data_i, int_i, status_i, cause_i, epc_i,
    output cp0_write_en, cp0_write_addr, cp0_write_data, cp0_hw_wr, stall_o, flush_o,
           redirect_pc_o
  );

  modport master (
    output mem_valid_i, mem_pc_i, mem_bd_i, exc_valid_i, exc_code_i, exc_badvaddr_i,
           eret_i, mtc0_en_i, mtc0_addr_i, mtc0_data_i, int_i, status_i, cause_i, epc_i,
    input  cp0_write_en, cp0_write_addr, cp0_write_data, cp0_hw_wr, stall_o, flush_o,
           redirect_pc_o
  );
endinterface

// File: rtl/cp0_exc_seq_int_detect.sv
// Hardware-interrupt acceptance: an unmasked pending line is taken only when
// interrupts are enabled, not already at exception level, and an instruction
// is committing to carry the EPC.
module cp0_int_detect #(
  parameter int INT_W = 6
) (
  input  logic             mem_valid_i,
  input  logic [INT_W-1:0] int_i,
  input  logic [INT_W-1:0] status_im_i,
  input  logic             status_ie_i,
  input  logic             status_exl_i,
  output logic             int_req_o
);

  assign int_req_o = mem_valid_i & status_ie_i & ~status_exl_i & (|(int_i & status_im_i));

endmodule

// File: rtl/cp0_exc_seq.sv
// Exception/ERET sequencer and CP0 write-port arbiter. Serialises the CP0
// writes of an exception (EPC, BadVAddr, Cause, Status) or ERET (Status),
// holds the pipeline meanwhile, then flushes and redirects fetch. MTC0 from
// the pipeline uses the same write port when no higher event is present.
module cp0_exc_seq
  import cp0_exc_seq_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter int          ADDR_W     = 5,
  parameter int          INT_W      = 6
) (
  input logic         clk,
  input logic         rst,
  cp0_exc_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EPC    = 3'd1,
    S_BADV   = 3'd2,
    S_CAUSE  = 3'd3,
    S_STATUS = 3'd4,
    S_ERET   = 3'd5,
    S_FLUSH  = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [4:0]        code_q, code_d;
  logic [31:0]       pc_q, pc_d;
  logic              bd_q, bd_d;
  logic [31:0]       badv_q, badv_d;
  logic              is_eret_q, is_eret_d;
  logic [31:0]       epc_q, epc_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              hw_wr_q, hw_wr_d;
  logic              flush_q, flush_d;
  logic [31:0]       redir_q, redir_d;
  logic              mtc0_go_s;
  logic              int_req_s;

  cp0_int_detect #(.INT_W(INT_W)) u_int_detect (
    .mem_valid_i  (bus.mem_valid_i),
    .int_i        (bus.int_i),
    .status_im_i  (bus.status_i[STATUS_IM_LO +: INT_W]),
    .status_ie_i  (bus.status_i[STATUS_IE]),
    .status_exl_i (bus.status_i[STATUS_EXL]),
    .int_req_o    (int_req_s)
  );

  // Hold the pipeline while an exception/interrupt/ERET is accepted or being sequenced.
  assign bus.stall_o = rst & ((state_q != S_IDLE) | int_req_s |
                              (bus.mem_valid_i & (bus.exc_valid_i | bus.eret_i)));

  // Next state, event arbitration in IDLE and capture of the accepted event.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    pc_d      = pc_q;
    bd_d      = bd_q;
    badv_d    = badv_q;
    is_eret_d = is_eret_q;
    epc_d     = epc_q;
    mtc0_go_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (int_req_s || (bus.mem_valid_i && bus.exc_valid_i)) begin
          code_d    = int_req_s ? EXC_INT : bus.exc_code_i;
          pc_d      = bus.mem_pc_i;
          bd_d      = bus.mem_bd_i;
          badv_d    = bus.exc_badvaddr_i;
          is_eret_d = 1'b0;
          // Already at exception level: keep the original EPC.
          if (!bus.status_i[STATUS_EXL]) begin
            state_d = S_EPC;
          end else if (!int_req_s && has_badvaddr(bus.exc_code_i)) begin
            state_d = S_BADV;
          end else begin
            state_d = S_CAUSE;
          end
        end else if (bus.mem_valid_i && bus.eret_i) begin
          epc_d     = bus.epc_i;
          is_eret_d = 1'b1;
          state_d   = S_ERET;
        end else if (bus.mem_valid_i && bus.mtc0_en_i) begin
          mtc0_go_s = 1'b1;
        end else begin
          mtc0_go_s = 1'b0;
        end
      end
      S_EPC:    state_d = has_badvaddr(code_q) ? S_BADV : S_CAUSE;
      S_BADV:   state_d = S_CAUSE;
      S_CAUSE:  state_d = S_STATUS;
      S_STATUS: state_d = S_FLUSH;
      S_ERET:   state_d = S_FLUSH;
      S_FLUSH:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Registered-output values for the state being entered.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = 32'h0000_0000;
    hw_wr_d   = 1'b0;
    flush_d   = 1'b0;
    redir_d   = 32'h0000_0000;
    case (state_d)
      S_IDLE: begin
        if (mtc0_go_s) begin
          wr_en_d   = 1'b1;
          wr_addr_d = bus.mtc0_addr_i;
          wr_data_d = bus.mtc0_data_i;
        end else begin
          wr_en_d   = 1'b0;
        end
      end
      S_EPC: begin
        wr_en_d   = 1'b1;
        hw_wr_d   = 1'b1;
        wr_addr_d = ADDR_W'(CP0_EPC);
        wr_data_d = bd_d ? (pc_d - 32'd4) : pc_d;
      end
      S_BADV: begin
        wr_en_d   = 1'b1;
        hw_wr_d   = 1'b1;
        wr_addr_d = ADDR_W'(CP0_BADVADDR);
        wr_data_d = badv_d;
      end
      S_CAUSE: begin
        wr_en_d   = 1'b1;
        hw_wr_d   = 1'b1;
        wr_addr_d = ADDR_W'(CP0_CAUSE);
        wr_data_d = {bd_d, bus.cause_i[30:7], code_d, bus.cause_i[1:0]};
      end
      S_STATUS: begin
        wr_en_d   = 1'b1;
        hw_wr_d   = 1'b1;
        wr_addr_d = ADDR_W'(CP0_STATUS);
        wr_data_d = {bus.status_i[31:2], 1'b1, bus.status_i[0]};
      end
      S_ERET: begin
        wr_en_d   = 1'b1;
        hw_wr_d   = 1'b1;
        wr_addr_d = ADDR_W'(CP0_STATUS);
        wr_data_d = {bus.status_i[31:2], 1'b0, bus.status_i[0]};
      end
      S_FLUSH: begin
        flush_d = 1'b1;
        redir_d = is_eret_d ? epc_d : EXC_VECTOR;
      end
      default: begin
        wr_en_d = 1'b0;
      end
    endcase
  end

  // State, captured event and output registers; async reset aborts to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      code_q    <= 5'd0;
      pc_q      <= 32'h0000_0000;
      bd_q      <= 1'b0;
      badv_q    <= 32'h0000_0000;
      is_eret_q <= 1'b0;
      epc_q     <= 32'h0000_0000;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 32'h0000_0000;
      hw_wr_q   <= 1'b0;
      flush_q   <= 1'b0;
      redir_q   <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      pc_q      <= pc_d;
      bd_q      <= bd_d;
      badv_q    <= badv_d;
      is_eret_q <= is_eret_d;
      epc_q     <= epc_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      hw_wr_q   <= hw_wr_d;
      flush_q   <= flush_d;
      redir_q   <= redir_d;
    end
  end

  assign bus.cp0_write_en   = wr_en_q;
  assign bus.cp0_write_addr = wr_addr_q;
  assign bus.cp0_write_data = wr_data_q;
  assign bus.cp0_hw_wr      = hw_wr_q;
  assign bus.flush_o        = flush_q;
  assign bus.redirect_pc_o  = redir_q;

endmodule

// File: tb/tb_cp0_exc_seq.sv
// Directed bench for the CP0 exception sequencer. Each cycle of a sequence is
// compared as one packed vector {en, hw_wr, flush, addr, data, redirect}.
module tb_cp0_exc_seq;
  import cp0_exc_seq_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cp0_exc_seq_if bus ();

  cp0_exc_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [71:0] obs_s;
  assign obs_s = {bus.cp0_write_en, bus.cp0_hw_wr, bus.flush_o, bus.cp0_write_addr,
                  bus.cp0_write_data, bus.redirect_pc_o};

  localparam logic [71:0] IDLE_V = 72'h0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [71:0] ev(input logic en, input logic hw, input logic fl,
                                     input logic [4:0] a, input logic [31:0] d,
                                     input logic [31:0] r);
    return {en, hw, fl, a, d, r};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_commit;
    bus.mem_valid_i = 1'b0;
    bus.exc_valid_i = 1'b0;
    bus.eret_i      = 1'b0;
    bus.mtc0_en_i   = 1'b0;
    bus.int_i       = 6'b000000;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    clear_commit();
    bus.mem_pc_i = 32'h0; bus.mem_bd_i = 1'b0; bus.exc_code_i = 5'd0;
    bus.exc_badvaddr_i = 32'h0; bus.mtc0_addr_i = 5'd0; bus.mtc0_data_i = 32'h0;
    bus.status_i = 32'h0; bus.cause_i = 32'h0; bus.epc_i = 32'h0;
    tick(); tick();
    checks++;
    if (obs_s !== IDLE_V) begin
      errors++; $display("FAIL reset_outputs got %h want %h", obs_s, IDLE_V);
    end
    checks++;
    if (bus.stall_o !== 1'b0) begin
      errors++; $display("FAIL reset_stall got %b want 0", bus.stall_o);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_exc_ov;
    logic [71:0] exp_v [5];
    exp_v[0] = ev(1'b1, 1'b1, 1'b0, 5'd14, 32'h8000_0FFC, 32'h0);
    exp_v[1] = ev(1'b1, 1'b1, 1'b0, 5'd13, 32'h8000_0030, 32'h0);
    exp_v[2] = ev(1'b1, 1'b1, 1'b0, 5'd12, 32'h0000_0002, 32'h0);
    exp_v[3] = ev(1'b0, 1'b0, 1'b1, 5'd0,  32'h0, 32'hBFC0_0380);
    exp_v[4] = IDLE_V;
    bus.status_i = 32'h0; bus.cause_i = 32'h0;
    bus.mem_valid_i = 1'b1; bus.exc_valid_i = 1'b1; bus.exc_code_i = EXC_OV;
    bus.mem_pc_i = 32'h8000_1000; bus.mem_bd_i = 1'b1;
    #1;
    checks++;
    if (bus.stall_o !== 1'b1) begin
      errors++; $display("FAIL ov_accept_stall got %b want 1", bus.stall_o);
    end
    tick();
    clear_commit();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs_s !== exp_v[i]) begin
        errors++; $display("FAIL ov_seq[%0d] got %h want %h", i, obs_s, exp_v[i]);
      end
      tick();
    end
  endtask

  task automatic test_exc_adel;
    logic [71:0] exp_v [6];
    exp_v[0] = ev(1'b1, 1'b1, 1'b0, 5'd14, 32'h8000_0100, 32'h0);
    exp_v[1] = ev(1'b1, 1'b1, 1'b0, 5'd8,  32'h8000_0003, 32'h0);
    exp_v[2] = ev(1'b1, 1'b1, 1'b0, 5'd13, 32'h0000_0010, 32'h0);
    exp_v[3] = ev(1'b1, 1'b1, 1'b0, 5'd12, 32'h0000_0002, 32'h0);
    exp_v[4] = ev(1'b0, 1'b0, 1'b1, 5'd0,  32'h0, 32'hBFC0_0380);
    exp_v[5] = IDLE_V;
    bus.status_i = 32'h0; bus.cause_i = 32'h0;
    bus.mem_valid_i = 1'b1; bus.exc_valid_i = 1'b1; bus.exc_code_i = EXC_ADEL;
    bus.mem_pc_i = 32'h8000_0100; bus.mem_bd_i = 1'b0; bus.exc_badvaddr_i = 32'h8000_0003;
    tick();
    clear_commit();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (obs_s !== exp_v[i]) begin
        errors++; $display("FAIL adel_seq[%0d] got %h want %h", i, obs_s, exp_v[i]);
      end
      tick();
    end
  endtask

  task automatic test_eret;
    logic [71:0] exp_v [3];
    exp_v[0] = ev(1'b1, 1'b1, 1'b0, 5'd12, 32'h0000_0001, 32'h0);
    exp_v[1] = ev(1'b0, 1'b0, 1'b1, 5'd0,  32'h0, 32'h8000_2000);
    exp_v[2] = IDLE_V;
    bus.status_i = 32'h0000_0003; bus.cause_i = 32'h0; bus.epc_i = 32'h8000_2000;
    bus.mem_valid_i = 1'b1; bus.eret_i = 1'b1;
    #1;
    checks++;
    if (bus.stall_o !== 1'b1) begin
      errors++; $display("FAIL eret_accept_stall got %b want 1", bus.stall_o);
    end
    tick();
    clear_commit();
    bus.epc_i = 32'h0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_s !== exp_v[i]) begin
        errors++; $display("FAIL eret_seq[%0d] got %h want %h", i, obs_s, exp_v[i]);
      end
      tick();
    end
  endtask

  task automatic test_int_vs_mtc0;
    logic [71:0] exp_v [5];
    exp_v[0] = ev(1'b1, 1'b1, 1'b0, 5'd14, 32'h8000_3000, 32'h0);
    exp_v[1] = ev(1'b1, 1'b1, 1'b0, 5'd13, 32'h0000_0400, 32'h0);
    exp_v[2] = ev(1'b1, 1'b1, 1'b0, 5'd12, 32'h0000_0403, 32'h0);
    exp_v[3] = ev(1'b0, 1'b0, 1'b1, 5'd0,  32'h0, 32'hBFC0_0380);
    exp_v[4] = IDLE_V;
    bus.status_i = 32'h0000_0401; bus.cause_i = 32'h0000_0400;
    bus.int_i = 6'b000001; bus.mem_valid_i = 1'b1; bus.mem_pc_i = 32'h8000_3000;
    bus.mem_bd_i = 1'b0; bus.mtc0_en_i = 1'b1; bus.mtc0_addr_i = 5'd11;
    bus.mtc0_data_i = 32'h1234_5678;
    #1;
    checks++;
    if (bus.stall_o !== 1'b1) begin
      errors++; $display("FAIL int_accept_stall got %b want 1", bus.stall_o);
    end
    tick();
    clear_commit();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs_s !== exp_v[i]) begin
        errors++; $display("FAIL int_seq[%0d] got %h want %h", i, obs_s, exp_v[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back_mtc0;
    logic [71:0] want;
    bus.status_i = 32'h0000_0403;
    bus.int_i = 6'b000001; bus.mem_valid_i = 1'b1; bus.mtc0_en_i = 1'b1;
    bus.mtc0_addr_i = 5'd11; bus.mtc0_data_i = 32'h1234_5678;
    #1;
    checks++;
    if (bus.stall_o !== 1'b0) begin
      errors++; $display("FAIL exl_mtc0_stall got %b want 0", bus.stall_o);
    end
    tick();
    want = ev(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0) | ev(1'b1, 1'b0, 1'b0, 5'd11, 32'h1234_5678, 32'h0);
    checks++;
    if (obs_s !== want) begin
      errors++; $display("FAIL mtc0_first got %h want %h", obs_s, want);
    end
    bus.mtc0_addr_i = 5'd9; bus.mtc0_data_i = 32'hCAFE_F00D;
    tick();
    want = ev(1'b1, 1'b0, 1'b0, 5'd9, 32'hCAFE_F00D, 32'h0);
    checks++;
    if (obs_s !== want) begin
      errors++; $display("FAIL mtc0_second got %h want %h", obs_s, want);
    end
    clear_commit();
    tick();
    checks++;
    if (obs_s !== IDLE_V) begin
      errors++; $display("FAIL mtc0_idle got %h want %h", obs_s, IDLE_V);
    end
  endtask

  task automatic test_sys_exl;
    logic [71:0] exp_v [4];
    exp_v[0] = ev(1'b1, 1'b1, 1'b0, 5'd13, 32'h0000_0020, 32'h0);
    exp_v[1] = ev(1'b1, 1'b1, 1'b0, 5'd12, 32'h0000_0002, 32'h0);
    exp_v[2] = ev(1'b0, 1'b0, 1'b1, 5'd0,  32'h0, 32'hBFC0_0380);
    exp_v[3] = IDLE_V;
    bus.status_i = 32'h0000_0002; bus.cause_i = 32'h0;
    bus.mem_valid_i = 1'b1; bus.exc_valid_i = 1'b1; bus.exc_code_i = EXC_SYS;
    bus.mem_pc_i = 32'h8000_4000; bus.mem_bd_i = 1'b0;
    tick();
    clear_commit();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_s !== exp_v[i]) begin
        errors++; $display("FAIL sys_exl_seq[%0d] got %h want %h", i, obs_s, exp_v[i]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_seq;
    logic [71:0] want;
    bus.status_i = 32'h0; bus.cause_i = 32'h0;
    bus.mem_valid_i = 1'b1; bus.exc_valid_i = 1'b1; bus.exc_code_i = EXC_OV;
    bus.mem_pc_i = 32'h8000_5000; bus.mem_bd_i = 1'b0;
    tick();
    clear_commit();
    tick();
    want = ev(1'b1, 1'b1, 1'b0, 5'd13, 32'h0000_0030, 32'h0);
    checks++;
    if (obs_s !== want) begin
      errors++; $display("FAIL midrst_in_cause got %h want %h", obs_s, want);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (obs_s !== IDLE_V) begin
      errors++; $display("FAIL midrst_outputs got %h want %h", obs_s, IDLE_V);
    end
    checks++;
    if (bus.stall_o !== 1'b0) begin
      errors++; $display("FAIL midrst_stall got %b want 0", bus.stall_o);
    end
    tick();
    rst = 1'b1;
    bus.mem_valid_i = 1'b1; bus.mtc0_en_i = 1'b1;
    bus.mtc0_addr_i = 5'd11; bus.mtc0_data_i = 32'h0000_00A5;
    tick();
    clear_commit();
    want = ev(1'b1, 1'b0, 1'b0, 5'd11, 32'h0000_00A5, 32'h0);
    checks++;
    if (obs_s !== want) begin
      errors++; $display("FAIL midrst_idle_mtc0 got %h want %h", obs_s, want);
    end
    tick();
    checks++;
    if (obs_s !== IDLE_V) begin
      errors++; $display("FAIL midrst_quiet got %h want %h", obs_s, IDLE_V);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_exc_ov();
    test_exc_adel();
    test_eret();
    test_int_vs_mtc0();
    test_back_to_back_mtc0();
    test_sys_exl();
    test_reset_mid_seq();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
